irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller_if.sv | 33 +++
 rtl/irq_controller.sv | 165 ++++++++++++++++
 tb/tb_irq_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller_if
//  Description : CPU-side handshake (irq/vector/ack/global_ie) and I/O slave
//                control signals for irq_controller. The tristate bus_data
//                line stays a plain inout port on the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface irq_controller_if #(
  parameter int I_ADDR_WIDTH = 10
);
  logic                    global_ie;
  logic                    irq;
  logic [I_ADDR_WIDTH-1:0] vector;
  logic                    ack;
  logic [15:0]             bus_addr;
  logic                    io_cs;
  logic                    io_we;
  logic                    io_oe;

  // CPU side: consumes the request, drives acceptance and bus control
  modport master (
    input  irq, vector,
    output global_ie, ack, bus_addr, io_cs, io_we, io_oe
  );

  // Controller side
  modport slave (
    output irq, vector,
    input  global_ie, ack, bus_addr, io_cs, io_we, io_oe
  );
endinterface
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller
//  Description : Prioritised interrupt controller with mask/pending I/O
//                registers and an IDLE/REQUEST/HOLDOFF request handshake.
//                Lowest-numbered eligible source wins.
//  Options     : IRQ_EDGE_EN - when defined, sources are synchronised and
//                rising edges latch pending bits (cleared by ack or by
//                write-1-to-clear); otherwise pending mirrors the registered
//                source level.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int          IRQ_COUNT    = 8,
  parameter int          I_ADDR_WIDTH = 10,
  parameter int          VECTOR_BASE  = 1,
  parameter logic [15:0] MASK_ADDR    = 16'h003D,
  parameter logic [15:0] FLAG_ADDR    = 16'h003C
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic [IRQ_COUNT-1:0] sources,
  irq_controller_if.slave           cpu,
  inout  wire logic [7:0]           bus_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_irq;
  logic [I_ADDR_WIDTH-1:0] r_vector;
  logic [IRQ_COUNT-1:0]    r_mask;
  logic [IRQ_COUNT-1:0]    r_pending;

  logic                    w_mask_sel;
  logic                    w_flag_sel;
  logic                    w_mask_wr;
  logic                    w_rd_en;
  logic [7:0]              w_rd_data;
  logic [IRQ_COUNT-1:0]    w_eligible;
  logic                    w_any;
  logic [2:0]              w_win_idx;
  logic                    w_grant;

  assign w_mask_sel = (cpu.bus_addr == MASK_ADDR);
  assign w_flag_sel = (cpu.bus_addr == FLAG_ADDR);
  assign w_mask_wr  = cpu.io_cs & cpu.io_we & w_mask_sel;
  assign w_rd_en    = cpu.io_cs & cpu.io_oe & (w_mask_sel | w_flag_sel);

  assign w_eligible = r_pending & r_mask;
  assign w_any      = |w_eligible;
  assign w_grant    = (r_state == IDLE) & cpu.global_ie & w_any;

  // Priority encoder: scanning downward lets the lowest set index win
  always_comb begin
    w_win_idx = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_win_idx = 3'(i);
    end
  end

  // Mask register, loaded from the low bits of the data bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_mask <= '0;
    else if (w_mask_wr) r_mask <= bus_data[IRQ_COUNT-1:0];
  end

`ifdef IRQ_EDGE_EN
  logic [IRQ_COUNT-1:0] r_sync1;
  logic [IRQ_COUNT-1:0] r_sync2;
  logic [IRQ_COUNT-1:0] r_prev;
  logic [IRQ_COUNT-1:0] w_event;
  logic [IRQ_COUNT-1:0] w_clr;
  logic [2:0]           r_idx;

  assign w_event = r_sync2 & ~r_prev;

  // Two-flop synchroniser plus edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= sources;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Clear requests: write-1-to-clear from the bus and the acknowledged source
  always_comb begin
    w_clr = '0;
    if (cpu.io_cs & cpu.io_we & w_flag_sel) w_clr = bus_data[IRQ_COUNT-1:0];
    if ((r_state == REQUEST) && cpu.ack) w_clr[r_idx] = 1'b1;
  end

  // Latch the granted index so ack clears the source actually serviced
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_idx <= '0;
    else if (w_grant) r_idx <= w_win_idx;
  end

  // Pending flags: a new event in the same cycle beats any clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pending <= '0;
    else r_pending <= (r_pending & ~w_clr) | w_event;
  end
`else
  // Pending mirrors the registered source level; the peripheral clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pending <= '0;
    else r_pending <= sources;
  end
`endif

  // Request handshake; irq and vector are frozen while a request is open
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_irq    <= 1'b0;
      r_vector <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state  <= REQUEST;
            r_irq    <= 1'b1;
            r_vector <= I_ADDR_WIDTH'(VECTOR_BASE) + I_ADDR_WIDTH'(w_win_idx);
          end
        end
        REQUEST: begin
          if (cpu.ack) begin
            r_state <= HOLDOFF;
            r_irq   <= 1'b0;
          end
        end
        HOLDOFF: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  // Read mux, zero-extended to the 8-bit bus
  always_comb begin
    w_rd_data = '0;
    if (w_mask_sel) w_rd_data[IRQ_COUNT-1:0] = r_mask;
    else            w_rd_data[IRQ_COUNT-1:0] = r_pending;
  end

  assign bus_data   = w_rd_en ? w_rd_data : 8'bz;
  assign cpu.irq    = r_irq;
  assign cpu.vector = r_vector;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_controller
//  Description : Self-checking bench for irq_controller. Expected vectors are
//                queued when sources are driven and popped when irq rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  localparam int          c_AW   = 10;
  localparam logic [15:0] c_MASK = 16'h003D;
  localparam logic [15:0] c_FLAG = 16'h003C;
`ifdef IRQ_EDGE_EN
  localparam int c_LAT = 4;
`else
  localparam int c_LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sources = '0;
  logic [7:0] r_tb_wdata = '0;
  logic       r_tb_drive = 1'b0;
  wire  [7:0] bus_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [c_AW-1:0] exp_q[$];

  assign bus_data = r_tb_drive ? r_tb_wdata : 8'bz;

  irq_controller_if #(.I_ADDR_WIDTH(c_AW)) cpu ();

  irq_controller #(
    .IRQ_COUNT   (8),
    .I_ADDR_WIDTH(c_AW),
    .VECTOR_BASE (1),
    .MASK_ADDR   (c_MASK),
    .FLAG_ADDR   (c_FLAG)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sources (sources),
    .cpu     (cpu),
    .bus_data(bus_data)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Advance n cycles, leaving time just past the rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    cpu.bus_addr = a; cpu.io_cs = 1'b1; cpu.io_we = 1'b1;
    r_tb_wdata = d; r_tb_drive = 1'b1;
    tick(1);
    cpu.io_cs = 1'b0; cpu.io_we = 1'b0; r_tb_drive = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
    cpu.bus_addr = a; cpu.io_cs = 1'b1; cpu.io_oe = 1'b1;
    #2;
    d = bus_data;
    cpu.io_cs = 1'b0; cpu.io_oe = 1'b0;
    #1;
  endtask

  // Wait (bounded) for irq, then pop the scoreboard and compare the vector
  task automatic wait_irq(input string tag, output int cyc);
    logic [c_AW-1:0] e;
    cyc = 0;
    while (cpu.irq !== 1'b1 && cyc < 20) begin
      tick(1);
      cyc++;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      if (cpu.irq !== 1'b1) chk({tag, "_timeout"}, 32'(cpu.irq), 32'd1);
      else chk(tag, 32'(cpu.vector), 32'(e));
    end
  endtask

  // One-cycle ack pulse, updating the source lines in the same cycle
  task automatic do_ack(input logic [7:0] new_src);
    cpu.ack = 1'b1; sources = new_src;
    tick(1);
    cpu.ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int cyc;
    cpu.global_ie = 1'b0; cpu.ack = 1'b0; cpu.bus_addr = '0;
    cpu.io_cs = 1'b0; cpu.io_we = 1'b0; cpu.io_oe = 1'b0;

    // Reset state
    tick(3);
    chk("rst_irq", 32'(cpu.irq), 32'd0);
    chk("rst_vector", 32'(cpu.vector), 32'd0);
    reset = 1'b1;
    tick(1);
    bus_rd(c_MASK, d); chk("rst_mask", 32'(d), 32'h00);
    bus_rd(c_FLAG, d); chk("rst_flag", 32'(d), 32'h00);

    // Single source, latency and ack handshake
    cpu.global_ie = 1'b1;
    bus_wr(c_MASK, 8'h01);
    bus_rd(c_MASK, d); chk("mask_rb", 32'(d), 32'h01);
    sources = 8'h01; exp_q.push_back(10'd1);
    wait_irq("src0_vec", cyc);
    chk("src0_lat", 32'(cyc), 32'(c_LAT));
    tick(3);
    chk("src0_hold_irq", 32'(cpu.irq), 32'd1);
    chk("src0_hold_vec", 32'(cpu.vector), 32'd1);
    do_ack(8'h00);
    chk("src0_ack_irq", 32'(cpu.irq), 32'd0);
    bus_rd(c_FLAG, d); chk("src0_pend_clr", 32'(d), 32'h00);
    tick(3);
    chk("src0_idle_irq", 32'(cpu.irq), 32'd0);

    // Two simultaneous sources: lower index first, then the other
    bus_wr(c_MASK, 8'hFF);
    sources = 8'h24; exp_q.push_back(10'd3); exp_q.push_back(10'd6);
    wait_irq("pri_first", cyc);
    chk("pri_lat", 32'(cyc), 32'(c_LAT));
    do_ack(8'h20);
    chk("pri_holdoff_irq", 32'(cpu.irq), 32'd0);
    chk("pri_holdoff_vec", 32'(cpu.vector), 32'd3);
    wait_irq("pri_second", cyc);
    chk("pri_rearm_lat", 32'(cyc), 32'd2);
    do_ack(8'h00);
    chk("pri2_ack_irq", 32'(cpu.irq), 32'd0);
    tick(3);

    // global_ie gating
    cpu.global_ie = 1'b0;
    sources = 8'h08; exp_q.push_back(10'd4);
    tick(6);
    chk("gie_off_irq", 32'(cpu.irq), 32'd0);
    bus_rd(c_FLAG, d); chk("gie_off_pend", 32'(d), 32'h08);
    cpu.global_ie = 1'b1;
    wait_irq("gie_on_vec", cyc);
    chk("gie_on_lat", 32'(cyc), 32'd1);
    do_ack(8'h00);
    tick(3);

    // Mask and flag writes while a request is open do not withdraw it
    sources = 8'h02; exp_q.push_back(10'd2);
    wait_irq("req_vec", cyc);
    bus_wr(c_MASK, 8'h00);
    bus_wr(c_FLAG, 8'hFF);
    tick(2);
    chk("req_stable_irq", 32'(cpu.irq), 32'd1);
    chk("req_stable_vec", 32'(cpu.vector), 32'd2);
    bus_rd(c_MASK, d); chk("req_mask_rb", 32'(d), 32'h00);
    do_ack(8'h00);
    chk("req_ack_irq", 32'(cpu.irq), 32'd0);
    tick(4);

    // Masked-out source stays pending but never requests
    bus_wr(c_MASK, 8'hFE);
    sources = 8'h01;
    tick(6);
    chk("masked_irq", 32'(cpu.irq), 32'd0);
    bus_rd(c_FLAG, d); chk("masked_pend", 32'(d), 32'h01);
    sources = 8'h00;
    bus_wr(c_FLAG, 8'h01);
    tick(3);

    // Reset during an open request
    bus_wr(c_MASK, 8'hFF);
    sources = 8'h80; exp_q.push_back(10'd8);
    wait_irq("src7_vec", cyc);
    reset = 1'b0;
    #1;
    chk("rst_req_irq", 32'(cpu.irq), 32'd0);
    chk("rst_req_vec", 32'(cpu.vector), 32'd0);
    sources = 8'h00;
    tick(2);
    reset = 1'b1;
    tick(1);
    bus_rd(c_MASK, d); chk("rst_req_mask", 32'(d), 32'h00);
    bus_rd(c_FLAG, d); chk("rst_req_flag", 32'(d), 32'h00);
    tick(4);
    chk("rst_req_idle", 32'(cpu.irq), 32'd0);

    // Mask selects among several active sources
    bus_wr(c_MASK, 8'hF0);
    sources = 8'h11; exp_q.push_back(10'd5);
    wait_irq("mask_pri_vec", cyc);
    do_ack(8'h00);
    tick(4);
    chk("final_irq", 32'(cpu.irq), 32'd0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
